// File: rtl/counter_fsm_unit_pkg.sv
// rtl/counter_fsm_unit_pkg.sv - shared state type and default window constants for the window timer
package counter_fsm_unit_pkg;

  // Window timer states: IDLE holds the counter at 0, COUNT runs the window
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Algorithm initialisation period: 3 s of samples at 360 Hz
  localparam int INIT_PERIOD_SAMPLES = 1080;
  localparam int INIT_PERIOD_WIDTH   = 11;

endpackage

// File: rtl/counter_fsm_unit_if.sv
// rtl/counter_fsm_unit_if.sv - start/enable/active signal bundle for the window timer
interface counter_fsm_unit_if;
  import counter_fsm_unit_pkg::*;

  logic i_ce;
  logic i_start;
  logic o_active;

  // Controller side: drives start and the sample enable, observes the window
  modport master (
    output i_ce,
    output i_start,
    input  o_active
  );

  // Timer side
  modport slave (
    input  i_ce,
    input  i_start,
    output o_active
  );

endinterface

// File: rtl/counter_fsm_unit.sv
// rtl/counter_fsm_unit.sv - one-shot retriggerable window timer counting i_ce-qualified cycles
module counter_fsm_unit
  import counter_fsm_unit_pkg::*;
#(
  parameter int MAX_VAL      = INIT_PERIOD_SAMPLES,
  parameter int MAX_VAL_SIZE = INIT_PERIOD_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  counter_fsm_unit_if.slave   bus
);

  // The window must be at least one cycle and the terminal value must fit the counter
  if (MAX_VAL < 1 || MAX_VAL >= (1 << MAX_VAL_SIZE)) begin : g_bad_max_val
    $error("counter_fsm_unit: MAX_VAL must be in 1 .. 2**MAX_VAL_SIZE-1");
  end

  // Last counter value of the window; equality compare, so the counter never wraps
  localparam logic [MAX_VAL_SIZE-1:0] TERMINAL = MAX_VAL_SIZE'(MAX_VAL - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [MAX_VAL_SIZE-1:0] cnt;
  logic [MAX_VAL_SIZE-1:0] cnt_nxt;

  // State and counter registers, cleared immediately on reset
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and window output; start always wins, even on the terminal count
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bus.o_active = (state == COUNT) || bus.i_start;

    if (bus.i_start) begin
      state_nxt = COUNT;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
        end
        COUNT: begin
          if (bus.i_ce) begin
            if (cnt == TERMINAL) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + MAX_VAL_SIZE'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_fsm_unit.sv
// tb/tb_counter_fsm_unit.sv - self-checking bench for the window timer
module tb_counter_fsm_unit;
  import counter_fsm_unit_pkg::*;

  typedef struct {
    logic start;
    logic ce;
    logic exp_active;
  } vec_t;

  logic clk = 1'b0;
  logic nrst;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  logic exp_q[$];

  always #5 clk = ~clk;

  counter_fsm_unit_if a_if ();
  counter_fsm_unit_if b_if ();

  counter_fsm_unit #(.MAX_VAL(4), .MAX_VAL_SIZE(3)) dut_a (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (a_if.slave)
  );

  counter_fsm_unit #(.MAX_VAL(INIT_PERIOD_SAMPLES), .MAX_VAL_SIZE(INIT_PERIOD_WIDTH)) dut_b (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (b_if.slave)
  );

  function automatic vec_t mk(input logic s, input logic c, input logic e);
    vec_t v;
    v.start      = s;
    v.ce         = c;
    v.exp_active = e;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b expected=%0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, sample at the falling edge
  task automatic step(input bit sel, input logic s, input logic ce, input logic exp, input string name);
    logic got;
    logic e;
    if (sel) begin
      b_if.i_start = s;
      b_if.i_ce    = ce;
    end else begin
      a_if.i_start = s;
      a_if.i_ce    = ce;
    end
    exp_q.push_back(exp);
    @(negedge clk);
    got = sel ? b_if.o_active : a_if.o_active;
    e   = exp_q.pop_front();
    check_bit(name, got, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // MAX_VAL=4, i_ce=1, single start: high cycles 0..4, low from 5
    vecs.push_back(mk(1, 1, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 1));
    vecs.push_back(mk(0, 1, 0));
    vecs.push_back(mk(0, 1, 0));
    // i_ce every other cycle: falls after the 4th sampled i_ce
    vecs.push_back(mk(1, 1, 1));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(0, 0, 1));
      vecs.push_back(mk(0, 1, 1));
    end
    vecs.push_back(mk(0, 0, 0));
    vecs.push_back(mk(0, 1, 0));
    // retrigger in cycle 2 and again exactly on the terminal count
    vecs.push_back(mk(1, 1, 1));
    vecs.push_back(mk(0, 1, 1));
    vecs.push_back(mk(1, 1, 1));
    vecs.push_back(mk(0, 1, 1));
    vecs.push_back(mk(0, 1, 1));
    vecs.push_back(mk(0, 1, 1));
    vecs.push_back(mk(1, 1, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 1));
    vecs.push_back(mk(0, 1, 0));
    // start with i_ce low still opens the window; i_ce low holds it
    vecs.push_back(mk(1, 0, 1));
    vecs.push_back(mk(0, 0, 1));
    vecs.push_back(mk(0, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 1));
    vecs.push_back(mk(0, 1, 0));

    a_if.i_start = 1'b0;
    a_if.i_ce    = 1'b0;
    b_if.i_start = 1'b0;
    b_if.i_ce    = 1'b0;
    nrst = 1'b0;

    // Reset state
    #12;
    check_bit("reset_active_a", a_if.o_active, 1'b0);
    check_bit("reset_active_b", b_if.o_active, 1'b0);
    check_int("reset_cnt_a", int'(dut_a.cnt), 0);
    check_int("reset_cnt_b", int'(dut_b.cnt), 0);
    a_if.i_start = 1'b1;
    #1;
    check_bit("reset_active_follows_start", a_if.o_active, 1'b1);
    a_if.i_start = 1'b0;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Idle for 50 cycles with i_ce high
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 1, 0, "idle_active");
      check_int("idle_cnt", int'(dut_a.cnt), 0);
    end

    // Table-driven vectors on the short window
    for (int i = 0; i < vecs.size(); i++) begin
      step(0, vecs[i].start, vecs[i].ce, vecs[i].exp_active, $sformatf("vec%0d", i));
    end

    // Full-length window, start held for 3 cycles: low from cycle 2+1080+1
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1, 1, "long_start_held");
      check_int("long_cnt_held", int'(dut_b.cnt), 0);
    end
    for (int k = 3; k <= 1084; k++) begin
      step(1, 0, 1, (k <= 2 + INIT_PERIOD_SAMPLES) ? 1'b1 : 1'b0, $sformatf("long_cycle%0d", k));
    end

    // Asynchronous reset mid-window with the counter at 2
    step(0, 1, 1, 1, "arst_start");
    step(0, 0, 1, 1, "arst_cnt1");
    step(0, 0, 1, 1, "arst_cnt2");
    check_int("arst_cnt_before", int'(dut_a.cnt), 2);
    a_if.i_start = 1'b0;
    a_if.i_ce    = 1'b1;
    #2 nrst = 1'b0;
    #1;
    check_bit("arst_active_drop", a_if.o_active, 1'b0);
    check_int("arst_cnt_clear", int'(dut_a.cnt), 0);
    a_if.i_start = 1'b1;
    #1;
    check_bit("arst_active_with_start", a_if.o_active, 1'b1);
    a_if.i_start = 1'b0;
    @(posedge clk);
    #3 nrst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "arst_after_release");
    step(0, 1, 1, 1, "arst_restart");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, "arst_restart_win");
    step(0, 0, 1, 0, "arst_restart_end");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_fsm_unit.md
# counter_fsm_unit

One-shot, retriggerable window timer. A start pulse (or level) opens an activity window lasting MAX_VAL clock-enable-qualified cycles, signalled on o_active. In the ECG R-peak detection chain it times the algorithm initialisation period (MAX_VAL = 360*3 = 1080 samples at 360 Hz) for the algorithm control FSM, which waits for o_active to fall before initialising the QRS threshold.

## Interface
- MAX_VAL, default 1080: window length in i_ce-qualified cycles; legal range 1 .. 2**MAX_VAL_SIZE-1.
- MAX_VAL_SIZE, default 11: counter width in bits.
- i_clk  input  1  clock, rising edge.
- i_nrst  input  1  reset; asynchronous, active-low.
- i_ce  input  1  clock enable; qualifies counting only.
- i_start  input  1  start/retrigger request, level-sensitive, sampled every clock regardless of i_ce.
- o_active  output  1  high while the window is open.

## Operation
- Reset is asynchronous and active-low on i_nrst; the clock is i_clk.
- There are two states:
  - IDLE (reset state): the counter holds 0.
  - COUNT: the window is running.
- Counter: MAX_VAL_SIZE bits, unsigned. Reset value is 0.
- Transitions, evaluated at each rising edge of i_clk:
  - If i_start = 1, the next state is COUNT and the counter is cleared to 0. This applies in either state, so a start during COUNT restarts the window.
  - In IDLE with i_start = 0: stay in IDLE.
  - In COUNT with i_start = 0 and i_ce = 0: hold the state and the counter.
  - In COUNT with i_start = 0, i_ce = 1 and counter < MAX_VAL-1: increment the counter.
  - In COUNT with i_start = 0, i_ce = 1 and counter = MAX_VAL-1: go to IDLE and clear the counter to 0.
- o_active = (state == COUNT) OR i_start. It is combinational from i_start, so the window is seen as active in the same cycle the start is presented. The control FSM relies on this, because its first wait cycle coincides with the start.
- The counter never wraps. The terminal compare is an equality test against MAX_VAL-1, truncated to MAX_VAL_SIZE.
- An elaboration-time check must fail if MAX_VAL < 1 or MAX_VAL >= 2**MAX_VAL_SIZE.

## Timing
- Reset values: state = IDLE and counter = 0. o_active equals i_start, which is 0 in normal use.
- Window length, counted after i_start falls: exactly MAX_VAL cycles with i_ce = 1. Cycles with i_ce = 0 stretch the window.
- With i_ce tied high, a single-cycle start in cycle 0 gives o_active high in cycles 0 .. MAX_VAL and low from cycle MAX_VAL+1. That is MAX_VAL+1 cycles in total.
- If i_start is held high for N cycles, the counter stays at 0 throughout, and o_active falls MAX_VAL i_ce-cycles after the last start cycle.
- i_start coinciding with the terminal count: start wins, and the window restarts with no low cycle on o_active.
- Asynchronous reset mid-window: state goes to IDLE and the counter to 0 immediately. o_active drops in that cycle unless i_start is high.
- An i_ce pulse in IDLE has no effect.

## Structure
- A shared package holds the state typedef (enum {IDLE, COUNT}). Default constants also go there: INIT_PERIOD_SAMPLES = 1080 and INIT_PERIOD_WIDTH = 11.
- The block is a single module with no sub-modules. It consists of:
  - one always_ff for state and counter, with asynchronous reset;
  - one always_comb for next-state logic and o_active.

## Test plan
- Reset, then idle with i_start = 0 and i_ce = 1 for 50 cycles -> o_active = 0 throughout and the counter stays at 0.
- MAX_VAL = 4, i_ce = 1, start pulse in cycle 0 -> o_active high in cycles 0–4, low in cycle 5.
- MAX_VAL = 4, i_ce high every other cycle, start pulse -> o_active stays high for 4 i_ce-high cycles after the start, then falls on the edge where the 4th i_ce is sampled.
- MAX_VAL = 1080, i_ce = 1, i_start held high for 3 cycles -> o_active is high continuously and falls exactly 1080 cycles after the last start cycle.
- MAX_VAL = 4, retrigger in cycle 2 and again at the terminal count -> the window extends and o_active never goes low between triggers.
- Assert i_nrst low mid-window (counter = 2) with i_start = 0 -> o_active falls asynchronously. After release it stays 0 until the next start.
